// File: rtl/imm_ext_stage_pkg.sv
// Shared decode definitions: instruction type, major opcodes and immediate format codes.
package imm_ext_stage_pkg;

    typedef logic [31:0] inst_t;

    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    // Value 7 is reserved.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/imm_ext_stage_decode.sv
// Combinational immediate-format classifier and sign/zero extender.
// IMM_EXT_ILLEGAL_EN adds an illegal-instruction flag that forces imm=0, fmt=R.
module imm_ext_decode
    import imm_ext_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  inst_t            inst_i,
    output logic [XLEN-1:0]  imm_o,
`ifdef IMM_EXT_ILLEGAL_EN
    output logic             illegal_o,
`endif
    output imm_fmt_e         fmt_o
);

    logic [6:0]      opc;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_full;
    imm_fmt_e        fmt;

    assign opc = inst_i[6:0];

    // Every format is first built sign-extended to 32 bits, then widened once.
    always_comb begin
        fmt   = FMT_I;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        case (opc)
            OP, OP_32: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
            SYSTEM: begin
                if (inst_i[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst_i[19:15]};
                end else begin
                    fmt   = FMT_R;
                    imm32 = '0;
                end
            end
            JAL: begin
                fmt   = FMT_J;
                imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt   = FMT_U;
                imm32 = {inst_i[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    if (XLEN > 32) begin : g_ext
        assign imm_full = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_noext
        assign imm_full = imm32;
    end

`ifdef IMM_EXT_ILLEGAL_EN
    logic known;
    assign known = opc inside {LOAD, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE,
                               OP, LUI, OP_32, BRANCH, JALR, JAL, SYSTEM};
    assign illegal_o = (inst_i[1:0] != 2'b11) || !known ||
                       ((opc == OP_32 || opc == OP_IMM_32) && XLEN == 32);
    assign imm_o = illegal_o ? '0 : imm_full;
    assign fmt_o = illegal_o ? FMT_R : fmt;
`else
    assign imm_o = imm_full;
    assign fmt_o = fmt;
`endif

endmodule

// File: rtl/imm_ext_stage.sv
// Registered valid/ready immediate-extraction stage: output register plus one skid entry.
// IMM_EXT_ILLEGAL_EN adds the out_illegal port carried with each entry.
module imm_ext_stage
    import imm_ext_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
`ifdef IMM_EXT_ILLEGAL_EN
    output logic             out_illegal,
`endif
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;

    logic             or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic [XLEN-1:0]  or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
    imm_fmt_e         or_fmt_q, or_fmt_d, sk_fmt_q, sk_fmt_d;
    logic [TAG_W-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
`ifdef IMM_EXT_ILLEGAL_EN
    logic             dec_ill;
    logic             or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
`endif
    logic             accept;

    imm_ext_decode #(.XLEN(XLEN)) u_dec (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
`ifdef IMM_EXT_ILLEGAL_EN
        .illegal_o (dec_ill),
`endif
        .fmt_o     (dec_fmt)
    );

    // Ready depends only on the skid flop (and reset), never on out_ready.
    assign in_ready = !sk_vld_q && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        or_vld_d = or_vld_q;
        or_imm_d = or_imm_q;
        or_fmt_d = or_fmt_q;
        or_tag_d = or_tag_q;
        sk_vld_d = sk_vld_q;
        sk_imm_d = sk_imm_q;
        sk_fmt_d = sk_fmt_q;
        sk_tag_d = sk_tag_q;
`ifdef IMM_EXT_ILLEGAL_EN
        or_ill_d = or_ill_q;
        sk_ill_d = sk_ill_q;
`endif
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || out_ready) begin
            // A held skid entry implies in_ready=0, so no accept competes with it.
            if (sk_vld_q) begin
                or_vld_d = 1'b1;
                or_imm_d = sk_imm_q;
                or_fmt_d = sk_fmt_q;
                or_tag_d = sk_tag_q;
`ifdef IMM_EXT_ILLEGAL_EN
                or_ill_d = sk_ill_q;
`endif
                sk_vld_d = 1'b0;
            end else begin
                or_vld_d = accept;
                if (accept) begin
                    or_imm_d = dec_imm;
                    or_fmt_d = dec_fmt;
                    or_tag_d = in_tag;
`ifdef IMM_EXT_ILLEGAL_EN
                    or_ill_d = dec_ill;
`endif
                end
            end
        end else if (accept) begin
            sk_vld_d = 1'b1;
            sk_imm_d = dec_imm;
            sk_fmt_d = dec_fmt;
            sk_tag_d = in_tag;
`ifdef IMM_EXT_ILLEGAL_EN
            sk_ill_d = dec_ill;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_vld_q <= 1'b0;
            or_imm_q <= '0;
            or_fmt_q <= FMT_R;
            or_tag_q <= '0;
            sk_vld_q <= 1'b0;
            sk_imm_q <= '0;
            sk_fmt_q <= FMT_R;
            sk_tag_q <= '0;
`ifdef IMM_EXT_ILLEGAL_EN
            or_ill_q <= 1'b0;
            sk_ill_q <= 1'b0;
`endif
        end else begin
            or_vld_q <= or_vld_d;
            or_imm_q <= or_imm_d;
            or_fmt_q <= or_fmt_d;
            or_tag_q <= or_tag_d;
            sk_vld_q <= sk_vld_d;
            sk_imm_q <= sk_imm_d;
            sk_fmt_q <= sk_fmt_d;
            sk_tag_q <= sk_tag_d;
`ifdef IMM_EXT_ILLEGAL_EN
            or_ill_q <= or_ill_d;
            sk_ill_q <= sk_ill_d;
`endif
        end
    end

    assign out_valid = or_vld_q;
    assign out_imm   = or_imm_q;
    assign out_fmt   = or_fmt_q;
    assign out_tag   = or_tag_q;
`ifdef IMM_EXT_ILLEGAL_EN
    assign out_illegal = or_ill_q;
`endif

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, handshaked immediate-extraction stage for the decode pipe.
- Takes a raw 32-bit instruction plus an opaque tag, classifies its immediate format, and produces the sign- or zero-extended immediate at XLEN width, one cycle later.
- Adds CSR zimm handling, an XLEN parameter (32/64), valid/ready flow control with a skid entry, and flush.
- Sits between fetch-buffer output and the register-read stage.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the opaque tag carried alongside each instruction (PC index / ROB id).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all held entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_inst  in  32  raw instruction.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  imm_fmt_e format code.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset, rst=1 sampled on clk:
  - out_valid=0; out_imm, out_fmt, out_tag = 0; skid entry invalid.
  - in_ready=0 while rst=1, and 1 from the first cycle after.
- Storage and handshake:
  - Two entries: output register (OR) and skid register (SK).
  - A transfer occurs on valid&ready, on each side.
  - in_ready = !SK.valid (registered, so there is no combinational path from out_ready).
  - Latency is 1 cycle: an instruction accepted at edge N appears on out_* after N when OR was empty or draining.
  - Throughput is 1/cycle while out_ready=1.
- OR empty or draining: an accepted input loads OR.
- OR full and stalled: an accepted input loads SK and in_ready drops.
  - When OR drains, SK moves to OR and in_ready returns to 1 the same cycle.
- Ordering is strict FIFO. out_* hold stable while out_valid=1 and out_ready=0.
- Flush:
  - OR.valid and SK.valid clear at the next edge.
  - An input offered in the flush cycle is dropped.
  - Flush has priority over accept and over drain.
  - Flush and rst together behave as rst.
- Format decode, from inst[6:0] (opcode constants in DEF):
  - OP, OP_32 -> R, imm 0.
  - SYSTEM, funct3[2]=1 -> Z, imm = zero-extended inst[19:15].
  - SYSTEM, otherwise -> R, imm 0.
  - JAL -> J: sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - STORE -> S: sext({i[31:25], i[11:7]}).
  - BRANCH -> B: sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - LUI, AUIPC -> U: sext({i[31:12], 12'b0}); at XLEN=32 this is unextended.
  - All other opcodes (OP_IMM, OP_IMM_32, LOAD, JALR, MISC_MEM, unknown) -> I: sext(i[31:20]).
- Width rule: "sext" replicates the field MSB up to XLEN. Results are exact at both XLEN values.
- imm_fmt_e encoding: R=0, I=1, S=2, B=3, U=4, J=5, Z=6. Value 7 is reserved.

Optional Feature:
- Macro: IMM_EXT_ILLEGAL_EN.
- Defined:
  - Adds port out_illegal (out, 1, reset 0), travelling with the entry.
  - out_illegal is set when in_inst[1:0] != 2'b11, when the opcode is outside the known set, or when the opcode is OP_32/OP_IMM_32 with XLEN=32.
  - An illegal entry has out_imm=0 and out_fmt=R.
- Undefined:
  - The port is absent.
  - Unknown opcodes decode as I, as above.

Decomposition:
- DEF package gains the typedef imm_fmt_e and the constant MISC_MEM, next to the existing opcode constants and inst_t.
- One combinational sub-module, imm_ext_decode:
  - Inputs: inst_t.
  - Outputs: imm (XLEN), fmt, and illegal when IMM_EXT_ILLEGAL_EN is defined.
  - Parameterised by XLEN.
- The handshake and storage logic stays in imm_ext_stage.

Test Plan:
- XLEN=64, out_ready=1, stream 0x800002B7, 0xFFF00093, 0xFE000EE3 -> results one per cycle, 1-cycle latency:
  - 0xFFFFFFFF80000000 with U.
  - 0xFFFFFFFFFFFFFFFF with I.
  - 0xFFFFFFFFFFFFFFFC with B.
- XLEN=64, 0x300FD073 (CSRRWI) -> imm 0x1F, fmt Z. Then 0x00000073 (ECALL) -> imm 0, fmt R.
- XLEN=32, 0x800002B7 -> imm 0x80000000, fmt U.
- out_ready=0, offer tags 1, 2, 3 back-to-back:
  - Tags 1 and 2 are accepted; in_ready=0 on the third cycle; tag 3 is held.
  - Release out_ready -> tags 1, 2, 3 emitted in order; out_* stable during the stall.
- OR and SK both full, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears.
- Reset mid-stream with both entries full -> all outputs 0 and in_ready=0 during rst. With IMM_EXT_ILLEGAL_EN, 0x00000000 -> out_illegal=1, imm 0.
